// File: rtl/nrs_ls_est_ctrl_if.sv
// Bus between the NRS LS-estimate sequencer and its datapath neighbours:
// the complex multiplier store port and the estimate readout handshake
// towards the interpolator.
interface nrs_ls_est_ctrl_if;
  logic       mult_en;
  logic [1:0] mult_wr_addr;
  logic [1:0] mult_rd_addr;
  logic       nrs_r;
  logic       nrs_i;
  logic       est_valid;
  logic       est_ready;
  logic [1:0] est_idx;

  // Sequencer side
  modport master (
    output mult_en,
    output mult_wr_addr,
    output mult_rd_addr,
    output nrs_r,
    output nrs_i,
    output est_valid,
    output est_idx,
    input  est_ready
  );

  // Multiplier / interpolator side
  modport slave (
    input  mult_en,
    input  mult_wr_addr,
    input  mult_rd_addr,
    input  nrs_r,
    input  nrs_i,
    input  est_valid,
    input  est_idx,
    output est_ready
  );
endinterface

// File: rtl/nrs_ls_est_ctrl.sv
// NRS least-squares channel-estimate sequencer for the NB-IoT receiver.
// Follows the resource-element stream of one slot, fires the multiplier
// store at the four NRS positions (two per NRS symbol) with the matching
// QPSK sign bits, then hands the four stored estimates to the interpolator
// over a valid/ready handshake.
module nrs_ls_est_ctrl #(
  parameter int N_SC  = 12,
  parameter int N_SYM = 7,
  parameter int SYM_A = 5,
  parameter int SYM_B = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2:0]                v_shift,
  input  logic [7:0]                nrs_seq,
  input  logic                      re_valid,
  nrs_ls_est_ctrl_if.master         est,
  output logic                      slot_done,
  output logic                      err_overrun,
  output logic                      err_count
);

  localparam logic [3:0] SC_LAST  = 4'(N_SC - 1);
  localparam logic [2:0] SYM_LAST = 3'(N_SYM - 1);
  localparam logic [2:0] SYM_A_L  = 3'(SYM_A);
  localparam logic [2:0] SYM_B_L  = 3'(SYM_B);

  typedef enum logic [1:0] {IDLE, COLLECT, READOUT} state_t;

  state_t     state;
  state_t     state_nxt;

  logic [2:0] vs;
  logic [7:0] seq;
  logic [3:0] sc_cnt;
  logic [2:0] sym_cnt;
  logic [2:0] wr_cnt;
  logic [2:0] wr_cnt_inc;
  logic [1:0] rd_cnt;
  logic [1:0] rd_addr;

  logic [1:0] wr_addr_q;
  logic       nrs_r_q;
  logic       nrs_i_q;
  logic       slot_done_q;
  logic       err_overrun_q;
  logic       err_count_q;

  logic [2:0] sc_mod6;
  logic [2:0] vs_b;
  logic       match;
  logic       wr_fire;
  logic       slot_end;
  logic       accept;
  logic       start_ok;

  // NRS position detect: symbol A uses vs, symbol B the subcarriers shifted by 3
  always_comb begin
    sc_mod6 = (sc_cnt >= 4'd6) ? 3'(sc_cnt - 4'd6) : sc_cnt[2:0];
    vs_b    = (vs >= 3'd3) ? (vs - 3'd3) : (vs + 3'd3);
    match   = ((sym_cnt == SYM_A_L) && (sc_mod6 == vs)) ||
              ((sym_cnt == SYM_B_L) && (sc_mod6 == vs_b));
  end

  // Next-state and per-cycle strobes of the slot sequencer
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    wr_fire   = 1'b0;
    slot_end  = 1'b0;
    accept    = 1'b0;
    rd_addr   = 2'd0;
    est.est_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        wr_fire = re_valid && match && (wr_cnt < 3'd4);
        if (re_valid && (sc_cnt == SC_LAST) && (sym_cnt == SYM_LAST)) begin
          slot_end  = 1'b1;
          state_nxt = READOUT;
        end
      end
      READOUT: begin
        est.est_valid = 1'b1;
        rd_addr       = rd_cnt;
        if (est.est_ready) begin
          accept = 1'b1;
          if (rd_cnt == 2'd3) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_cnt_inc       = wr_cnt + {2'b00, wr_fire};
  assign est.mult_en      = wr_fire;
  assign est.mult_wr_addr = wr_fire ? wr_cnt[1:0] : wr_addr_q;
  assign est.nrs_r        = wr_fire ? seq[{wr_cnt[1:0], 1'b1}] : nrs_r_q;
  assign est.nrs_i        = wr_fire ? seq[{wr_cnt[1:0], 1'b0}] : nrs_i_q;
  assign est.mult_rd_addr = rd_addr;
  assign est.est_idx      = rd_addr;
  assign slot_done        = slot_done_q;
  assign err_overrun      = err_overrun_q;
  assign err_count        = err_count_q;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Slot counters, latched slot configuration and write/read bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs      <= 3'd0;
      seq     <= 8'd0;
      sc_cnt  <= 4'd0;
      sym_cnt <= 3'd0;
      wr_cnt  <= 3'd0;
      rd_cnt  <= 2'd0;
    end else begin
      if (start_ok) begin
        vs      <= (v_shift >= 3'd6) ? (v_shift - 3'd6) : v_shift;
        seq     <= nrs_seq;
        sc_cnt  <= 4'd0;
        sym_cnt <= 3'd0;
        wr_cnt  <= 3'd0;
      end
      if ((state == COLLECT) && re_valid) begin
        if (sc_cnt == SC_LAST) begin
          sc_cnt  <= 4'd0;
          sym_cnt <= sym_cnt + 3'd1;
        end else begin
          sc_cnt <= sc_cnt + 4'd1;
        end
      end
      if (wr_fire) wr_cnt <= wr_cnt_inc;
      if (slot_end) rd_cnt <= 2'd0;
      else if (accept) rd_cnt <= rd_cnt + 2'd1;
    end
  end

  // Held multiplier write fields and the one-cycle status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr_q     <= 2'd0;
      nrs_r_q       <= 1'b0;
      nrs_i_q       <= 1'b0;
      slot_done_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      err_count_q   <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_addr_q <= wr_cnt[1:0];
        nrs_r_q   <= seq[{wr_cnt[1:0], 1'b1}];
        nrs_i_q   <= seq[{wr_cnt[1:0], 1'b0}];
      end
      slot_done_q   <= accept && (rd_cnt == 2'd3);
      err_overrun_q <= start && (state != IDLE);
      err_count_q   <= slot_end && (wr_cnt_inc != 3'd4);
    end
  end

endmodule

// File: tb/tb_nrs_ls_est_ctrl.sv
// Self-checking bench for nrs_ls_est_ctrl. The driver plays directed slots
// and queues the expected multiplier writes, readout cycles and status
// pulses; a monitor on the falling edge pops and compares whenever the DUT
// presents one of those outputs.
module tb_nrs_ls_est_ctrl;

  typedef struct {
    int re;
    int addr;
    int r;
    int i;
  } wr_t;

  typedef struct {
    int cyc;
    int idx;
  } ro_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] v_shift = 3'd0;
  logic [7:0] nrs_seq = 8'd0;
  logic       re_valid = 1'b0;
  logic       slot_done;
  logic       err_overrun;
  logic       err_count;

  nrs_ls_est_ctrl_if est_if ();

  nrs_ls_est_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .v_shift     (v_shift),
    .nrs_seq     (nrs_seq),
    .re_valid    (re_valid),
    .est         (est_if),
    .slot_done   (slot_done),
    .err_overrun (err_overrun),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  cur_re = -1;
  int  n_vec = 0;
  int  n_miss = 0;
  bit  done = 1'b0;

  wr_t wr_q[$];
  ro_t ro_q[$];
  int  sd_q[$];
  int  eo_q[$];
  int  rst_chk_q[$];
  wr_t ew;
  wr_t last_wr;
  ro_t er;
  int  es;

  logic [12:0] outs;
  assign outs = {est_if.mult_en, est_if.mult_wr_addr, est_if.mult_rd_addr,
                 est_if.nrs_r, est_if.nrs_i, est_if.est_valid, est_if.est_idx,
                 slot_done, err_overrun, err_count};

  // Cycle index, read by driver after the edge and by monitor mid-cycle
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One slot: start, 84 REs (optional gaps / overrun start / reset), readout
  task automatic applyStimulus(input logic [2:0] v, input logic [7:0] seq,
                               input int p0, input int p1, input int p2, input int p3,
                               input bit gaps, input int ovr_re, input int rst_re,
                               input logic [7:0] pat, input int pat_len, input bit busy_ro);
    int  pos[4];
    int  idx;
    wr_t e;
    ro_t r;
    pos = '{p0, p1, p2, p3};
    for (int n = 0; n < 4; n++) begin
      if (rst_re < 0 || pos[n] < rst_re) begin
        e.re   = pos[n];
        e.addr = n;
        e.r    = int'(seq[2*n+1]);
        e.i    = int'(seq[2*n]);
        wr_q.push_back(e);
      end
    end
    start    = 1'b1;
    v_shift  = v;
    nrs_seq  = seq;
    re_valid = 1'b1;
    cur_re   = -1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int re = 0; re < 84; re++) begin
      if (re == rst_re) begin
        rst      = 1'b0;
        re_valid = 1'b0;
        cur_re   = -1;
        rst_chk_q.push_back(1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        return;
      end
      if (gaps && (re % 5 == 4)) begin
        re_valid = 1'b0;
        cur_re   = -1;
        repeat (2) begin @(posedge clk); #1; end
      end
      re_valid = 1'b1;
      cur_re   = re;
      start    = (re == ovr_re);
      if (re == ovr_re) eo_q.push_back(cyc + 1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    re_valid = busy_ro;
    cur_re   = -1;
    idx      = 0;
    for (int k = 0; k < pat_len; k++) begin
      est_if.est_ready = pat[k];
      start = busy_ro && (k == 1);
      if (start) eo_q.push_back(cyc + 1);
      r.cyc = cyc;
      r.idx = idx;
      ro_q.push_back(r);
      if (pat[k]) begin
        idx++;
        if (idx == 4) sd_q.push_back(cyc + 1);
      end
      @(posedge clk); #1;
    end
    est_if.est_ready = 1'b0;
    re_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT presents an output
  always @(negedge clk) begin
    if (!rst) begin
      last_wr.re = 0; last_wr.addr = 0; last_wr.r = 0; last_wr.i = 0;
      if (rst_chk_q.size() != 0) begin
        es = rst_chk_q.pop_front();
        checkOutput("reset_outputs", int'(outs), 0);
      end
    end else begin
      if (est_if.mult_en) begin
        if (wr_q.size() == 0) checkOutput("spurious_write", 1, 0);
        else begin
          ew = wr_q.pop_front();
          checkOutput("write_re", cur_re, ew.re);
          checkOutput("write_addr", int'(est_if.mult_wr_addr), ew.addr);
          checkOutput("write_nrs_ri", int'({est_if.nrs_r, est_if.nrs_i}), ew.r * 2 + ew.i);
          last_wr = ew;
        end
      end
      if (est_if.est_valid) begin
        if (ro_q.size() == 0) checkOutput("spurious_est_valid", 1, 0);
        else begin
          er = ro_q.pop_front();
          checkOutput("est_cycle", cyc, er.cyc);
          checkOutput("est_idx", int'(est_if.est_idx), er.idx);
          checkOutput("rd_addr", int'(est_if.mult_rd_addr), er.idx);
          checkOutput("wr_hold", int'({est_if.mult_wr_addr, est_if.nrs_r, est_if.nrs_i}),
                      last_wr.addr * 4 + last_wr.r * 2 + last_wr.i);
        end
      end
      if (slot_done) begin
        if (sd_q.size() == 0) checkOutput("spurious_slot_done", 1, 0);
        else begin
          es = sd_q.pop_front();
          checkOutput("slot_done_cycle", cyc, es);
          checkOutput("rd_addr_idle", int'({est_if.mult_rd_addr, est_if.est_idx}), 0);
        end
      end
      if (err_overrun) begin
        if (eo_q.size() == 0) checkOutput("spurious_err_overrun", 1, 0);
        else begin
          es = eo_q.pop_front();
          checkOutput("err_overrun_cycle", cyc, es);
        end
      end
      if (err_count) checkOutput("err_count_pulse", 1, 0);
    end
    if (done || cyc > 20000) begin
      if (!done) checkOutput("watchdog_done", 0, 1);
      checkOutput("writes_missing", wr_q.size(), 0);
      checkOutput("readout_missing", ro_q.size(), 0);
      checkOutput("slot_done_missing", sd_q.size(), 0);
      checkOutput("err_overrun_missing", eo_q.size(), 0);
      checkOutput("reset_check_missing", rst_chk_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
    end
  end

  // Directed slot sequence
  initial begin
    est_if.est_ready = 1'b0;
    rst = 1'b0;
    rst_chk_q.push_back(1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    $display("[TB] reset released at cycle %0d", cyc);
    re_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    re_valid = 1'b0;
    // v_shift 0, back-to-back REs, est_ready held high
    applyStimulus(3'd0, 8'b10_01_11_00, 60, 66, 75, 81, 1'b0, -1, -1, 8'h0F, 4, 1'b0);
    // v_shift 5 with gaps, readout ready pattern 1,0,0,1,1,0,1
    applyStimulus(3'd5, 8'hB4, 65, 71, 74, 80, 1'b1, -1, -1, 8'h59, 7, 1'b0);
    // v_shift 2: last write on the slot-end RE; overrun starts at RE 30 and in readout
    applyStimulus(3'd2, 8'h5A, 62, 68, 77, 83, 1'b0, 30, -1, 8'h0F, 4, 1'b1);
    // reset mid-slot at RE 70 after two writes
    applyStimulus(3'd0, 8'h96, 60, 66, 75, 81, 1'b0, -1, 70, 8'h0F, 4, 1'b0);
    // normal slot after reset
    applyStimulus(3'd0, 8'h3C, 60, 66, 75, 81, 1'b0, -1, -1, 8'h0F, 4, 1'b0);
    // v_shift 7 behaves as v_shift 1
    applyStimulus(3'd7, 8'hE1, 61, 67, 76, 82, 1'b0, -1, -1, 8'h0F, 4, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    done = 1'b1;
  end

endmodule

// File: doc/nrs_ls_est_ctrl.md
# nrs_ls_est_ctrl

Sequencer for the NRS least-squares channel-estimate stage of the NB-IoT receiver. It tracks the resource-element stream of one slot and detects the four NRS positions (two subcarriers in each of the last two OFDM symbols). At each NRS position it drives the complex multiplier's write enable, write address and NRS sign bits. Once the slot is complete it reads the four stored estimates out to the interpolator through a valid/ready handshake.

## Interface
- N_SC, 12, subcarriers per OFDM symbol
- N_SYM, 7, OFDM symbols per slot
- SYM_A, 5, first NRS symbol index (v = 0)
- SYM_B, 6, second NRS symbol index (v = 3)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse at slot start; accepted only in IDLE
- v_shift  in  3  N_ID mod 6; sampled on accepted start
- nrs_seq  in  8  QPSK sign bits for the 4 NRS REs; bit 2n+1 = real sign, bit 2n = imag sign of RE n (1 = negative); sampled on accepted start
- re_valid  in  1  one slot RE presented this cycle, subcarrier-major order (sc 0..11 of sym 0, then sym 1, ...)
- mult_en  out  1  multiplier store enable (combinational)
- mult_wr_addr  out  2  multiplier write address
- mult_rd_addr  out  2  multiplier read address
- nrs_r, nrs_i  out  1  NRS sign bits for the current write
- est_valid  out  1  estimate at mult_rd_addr is valid
- est_ready  in  1  downstream accepts estimate
- est_idx  out  2  index of the estimate presented (equals mult_rd_addr)
- slot_done  out  1  one-cycle pulse after the last estimate is accepted
- err_overrun  out  1  one-cycle pulse: start seen while not IDLE
- err_count  out  1  one-cycle pulse: slot ended with write count != 4

## Operation
- States: IDLE, COLLECT, READOUT.
- IDLE: on start, latch vs = (v_shift >= 6 ? v_shift-6 : v_shift) and nrs_seq. Clear sc_cnt, sym_cnt, wr_cnt. Go to COLLECT.
- COLLECT: each re_valid advances sc_cnt 0..N_SC-1. On wrap, sc_cnt -> 0 and sym_cnt increments.
- NRS match: (sym_cnt == SYM_A and sc_cnt mod 6 == vs) or (sym_cnt == SYM_B and sc_cnt mod 6 == (vs+3) mod 6). This gives exactly 2 matches per NRS symbol.
- mult_en = re_valid & match & (state == COLLECT) & (wr_cnt < 4). In the same cycle: mult_wr_addr = wr_cnt[1:0], nrs_r = nrs_seq[2*wr_cnt+1], nrs_i = nrs_seq[2*wr_cnt]. wr_cnt increments after each write and saturates at 4.
- Slot end: re_valid on sc_cnt = N_SC-1, sym_cnt = N_SYM-1. Go to READOUT and clear rd_cnt. If wr_cnt != 4 (only possible if parameters are misconfigured), pulse err_count and still read out all 4 addresses.
- READOUT: est_valid = 1 and mult_rd_addr = est_idx = rd_cnt. When est_valid & est_ready, rd_cnt increments. On acceptance at rd_cnt = 3, go to IDLE and pulse slot_done.
- re_valid in IDLE or READOUT is ignored: no counter change, mult_en = 0.
- start in COLLECT or READOUT is ignored and pulses err_overrun. The current slot continues.
- When not writing, mult_wr_addr, nrs_r and nrs_i hold their last values. When not in READOUT, mult_rd_addr = 0.

## Timing
- Reset values (state IDLE; all counters 0): mult_en 0, mult_wr_addr 0, mult_rd_addr 0, nrs_r 0, nrs_i 0, est_valid 0, est_idx 0, slot_done 0, err_overrun 0, err_count 0.
- An accepted start takes effect on the next edge. An re_valid in the same cycle as start is ignored.
- mult_en is combinational with re_valid. The multiplier stores on the same rising edge.
- Slot-end RE at edge T: state = READOUT after T, est_valid high in cycle T+1. The multiplier's last write also lands at T, so the read is coherent.
- Best-case readout is 4 cycles with est_ready held high. est_valid stays high while est_ready is low; est_idx must not change until accepted.
- slot_done is asserted in the cycle after the 4th acceptance, with state = IDLE. A start in that cycle is accepted.
- Reset assertion mid-slot: all state clears immediately (asynchronous). Outputs take reset values. The multiplier contents are not this block's concern.

## Test plan
- v_shift=0, nrs_seq=8'b10_01_11_00, 84 back-to-back re_valid -> mult_en at RE 60, 66, 75, 81 (sym5 sc0,6; sym6 sc3,9), wr_addr 0..3, (nrs_r,nrs_i) = (0,0),(1,1),(0,1),(1,0); est_valid from the cycle after RE 83.
- v_shift=5 with gaps on re_valid -> writes at sym5 sc5,11 and sym6 sc2,8; counters hold during gaps.
- Readout with est_ready toggling 1,0,0,1,1,0,1 -> est_idx steps 0,1,1,1,2,3,3, then slot_done one cycle after the final acceptance; est_idx stable while est_ready = 0.
- start pulsed at RE 30 and again during READOUT -> err_overrun pulses twice; writes and readout unchanged.
- Reset asserted at RE 70 (after 2 writes) -> state IDLE, all outputs 0; a following start with 84 REs yields a normal 4-write slot.
- v_shift=7 -> same positions as v_shift=1 (sym5 sc1,7; sym6 sc4,10).
